// File: rtl/io_bus_pkg.sv
// Shared constants for the Risc16 memory-mapped I/O controller: register addresses,
// default bus width and the LED update operations.
package io_bus_pkg;

    localparam int DATA_W_DEF = 16;

    localparam logic [15:0] ADDR_SW       = 16'h0001;
    localparam logic [15:0] ADDR_BTN      = 16'h0002;
    localparam logic [15:0] ADDR_EDGE     = 16'h0003;
    localparam logic [15:0] ADDR_LED      = 16'h0004;
    localparam logic [15:0] ADDR_LED_SET  = 16'h0005;
    localparam logic [15:0] ADDR_LED_CLR  = 16'h0006;
    localparam logic [15:0] ADDR_LED_TGL  = 16'h0007;
    localparam logic [15:0] ADDR_TIMER    = 16'h0008;
    localparam logic [15:0] ADDR_IRQ_MASK = 16'h0009;

    typedef enum logic [2:0] {
        LED_NONE,
        LED_LOAD,
        LED_SET,
        LED_CLR,
        LED_TGL
    } led_op_e;

endpackage

// File: rtl/io_debounce.sv
// Two-flop synchroniser followed by a per-bit stability counter; the debounced bit
// follows the synchronised input only after it has differed for DEB_CYCLES cycles in a row.
module io_debounce #(
    parameter int W          = 5,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] raw_in,
    output logic [W-1:0] deb_out,
    output logic [W-1:0] rise_out
);

    localparam int             CNT_W    = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [W-1:0]             meta_d, meta_q;
    logic [W-1:0]             sync_d, sync_q;
    logic [W-1:0]             stable_d, stable_q;
    logic [W-1:0][CNT_W-1:0]  cnt_d, cnt_q;

    // NOTE: every output of always_comb gets a default first so no latch is inferred.
    always_comb begin
        meta_d   = raw_in;
        sync_d   = meta_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < W; i++) begin
            if (sync_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = sync_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so all flops sample together.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q   <= '0;
            sync_q   <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            meta_q   <= meta_d;
            sync_q   <= sync_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign deb_out  = stable_q;
    // Rise is flagged one cycle early so the edge latch sets together with the debounced bit.
    assign rise_out = stable_d & ~stable_q;

endmodule

// File: rtl/io_bus_ctrl.sv
// Memory-mapped I/O controller between the Risc16 io_* bus and the board switches,
// buttons and LEDs, with sticky button edges, a tick timer and a maskable interrupt.
module io_bus_ctrl
    import io_bus_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int SW_W       = 16,
    parameter int BTN_W      = 5,
    parameter int LED_W      = 16,
    parameter int DEB_CYCLES = 1000000,
    parameter int TICK_DIV   = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] io_address,
    input  logic [DATA_W-1:0] io_write_value,
    input  logic              io_write_en,
    input  logic              io_read_en,
    output logic [DATA_W-1:0] io_read_value,
    output logic              io_read_valid,
    input  logic [SW_W-1:0]   sw_in,
    input  logic [BTN_W-1:0]  btn_in,
    output logic [LED_W-1:0]  led_out,
    output logic              irq
);

    localparam int               PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [SW_W-1:0]   sw_meta_d, sw_meta_q;
    logic [SW_W-1:0]   sw_sync_d, sw_sync_q;
    logic [BTN_W-1:0]  btn_deb, btn_rise;
    logic [BTN_W-1:0]  edge_d, edge_q;
    logic [BTN_W-1:0]  mask_d, mask_q;
    logic [LED_W-1:0]  led_d, led_q;
    logic [DATA_W-1:0] timer_d, timer_q;
    logic [PRE_W-1:0]  pre_d, pre_q;
    logic [DATA_W-1:0] read_value_d, read_value_q;
    logic              read_valid_d, read_valid_q;
    logic              irq_d, irq_q;

    logic              sel_sw, sel_btn, sel_edge, sel_led, sel_timer, sel_mask;
    logic              tick;
    led_op_e           led_op;
    logic [DATA_W-1:0] rd_data;

    io_debounce #(
        .W          (BTN_W),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_btn_debounce (
        .clk      (clk),
        .rst      (rst),
        .raw_in   (btn_in),
        .deb_out  (btn_deb),
        .rise_out (btn_rise)
    );

    // Full-width compares: aliases of a register address must not decode.
    assign sel_sw    = (io_address == DATA_W'(ADDR_SW));
    assign sel_btn   = (io_address == DATA_W'(ADDR_BTN));
    assign sel_edge  = (io_address == DATA_W'(ADDR_EDGE));
    assign sel_led   = (io_address == DATA_W'(ADDR_LED));
    assign sel_timer = (io_address == DATA_W'(ADDR_TIMER));
    assign sel_mask  = (io_address == DATA_W'(ADDR_IRQ_MASK));

    assign tick = (pre_q == PRE_LAST);

    always_comb begin
        led_op = LED_NONE;
        if (io_write_en) begin
            if (sel_led)                                     led_op = LED_LOAD;
            else if (io_address == DATA_W'(ADDR_LED_SET))    led_op = LED_SET;
            else if (io_address == DATA_W'(ADDR_LED_CLR))    led_op = LED_CLR;
            else if (io_address == DATA_W'(ADDR_LED_TGL))    led_op = LED_TGL;
        end
    end

    always_comb begin
        rd_data = '0;
        if (sel_sw)         rd_data = DATA_W'(sw_sync_q);
        else if (sel_btn)   rd_data = DATA_W'(btn_deb) << (DATA_W - BTN_W);
        else if (sel_edge)  rd_data = DATA_W'(edge_q);
        else if (sel_led)   rd_data = DATA_W'(led_q);
        else if (sel_timer) rd_data = timer_q;
        else if (sel_mask)  rd_data = DATA_W'(mask_q);
    end

    always_comb begin
        sw_meta_d = sw_in;
        sw_sync_d = sw_meta_q;

        unique case (led_op)
            LED_LOAD: led_d = io_write_value[LED_W-1:0];
            LED_SET:  led_d = led_q | io_write_value[LED_W-1:0];
            LED_CLR:  led_d = led_q & ~io_write_value[LED_W-1:0];
            LED_TGL:  led_d = led_q ^ io_write_value[LED_W-1:0];
            default:  led_d = led_q;
        endcase

        // A timer write overrides a coincident tick.
        if (io_write_en && sel_timer) begin
            timer_d = io_write_value;
            pre_d   = '0;
        end else if (tick) begin
            timer_d = timer_q + 1'b1;
            pre_d   = '0;
        end else begin
            timer_d = timer_q;
            pre_d   = pre_q + 1'b1;
        end

        mask_d = (io_write_en && sel_mask) ? io_write_value[BTN_W-1:0] : mask_q;

        // Clear-on-read drops old edges but keeps one arriving in the same cycle.
        edge_d = ((io_read_en && sel_edge) ? '0 : edge_q) | btn_rise;

        irq_d = |(edge_d & mask_d);

        read_valid_d = io_read_en;
        read_value_d = io_read_en ? rd_data : read_value_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta_q    <= '0;
            sw_sync_q    <= '0;
            edge_q       <= '0;
            mask_q       <= '0;
            led_q        <= '0;
            timer_q      <= '0;
            pre_q        <= '0;
            read_value_q <= '0;
            read_valid_q <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            sw_meta_q    <= sw_meta_d;
            sw_sync_q    <= sw_sync_d;
            edge_q       <= edge_d;
            mask_q       <= mask_d;
            led_q        <= led_d;
            timer_q      <= timer_d;
            pre_q        <= pre_d;
            read_value_q <= read_value_d;
            read_valid_q <= read_valid_d;
            irq_q        <= irq_d;
        end
    end

    assign io_read_value = read_value_q;
    assign io_read_valid = read_valid_q;
    assign led_out       = led_q;
    assign irq           = irq_q;

endmodule
